dor_route_switch: RTL and testbench

Dimension-order-routed (X then Y) 3-input/3-output torus switch stage that consumes the outputs of the per-input shadow registers and drives registered outputs to the next hop. It generates the unregistered per-input backpressure that those shadow registers register, and it accepts registered backpressure from downstream.

---
 rtl/dor_route_switch.sv | 152 +++++++++++++++
 tb/tb_dor_route_switch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dor_route_switch.sv
// X-then-Y dimension-order torus switch stage: W/N/PE inputs to E/S/X registered outputs.
// Optional DOR_STARVE_EN: PE starvation counter that forces one PE grant after STARVE_LIM blocked cycles.
module dor_route_switch #(
   parameter int D_W        = 32,
   parameter int A_W        = 32,
   parameter int posx       = 0,
   parameter int posy       = 0,
   parameter int STARVE_LIM = 8,
   localparam int W         = A_W + D_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         w_v,
   input  logic [W-1:0] w_d,
   output logic         w_b,
   input  logic         n_v,
   input  logic [W-1:0] n_d,
   output logic         n_b,
   input  logic         pe_v,
   input  logic [W-1:0] pe_d,
   output logic         pe_b,
   output logic         e_v,
   output logic [W-1:0] e_d,
   input  logic         e_b,
   output logic         s_v,
   output logic [W-1:0] s_d,
   input  logic         s_b,
   output logic         x_v,
   output logic [W-1:0] x_d,
   input  logic         x_b
);
   localparam int H = A_W / 2;
   localparam logic [H-1:0] PX = H'(posx);
   localparam logic [H-1:0] PY = H'(posy);

   logic w_ex, w_ey, n_ey, pe_ex, pe_ey;
   logic w_re, w_rs, w_rx, n_rs, n_rx, pe_re, pe_rs, pe_rx;
   logic rdy_e, rdy_s, rdy_x;
   logic g_e_w, g_e_pe, g_s_n, g_s_w, g_s_pe, g_x_n, g_x_w, g_x_pe;
   logic w_g, n_g, pe_g, pe_pri;
   logic rr_s, rr_x, flip_s, flip_x;

   assign w_ex  = (w_d[D_W +: H] == PX);
   assign w_ey  = (w_d[D_W+H +: H] == PY);
   assign n_ey  = (n_d[D_W+H +: H] == PY);
   assign pe_ex = (pe_d[D_W +: H] == PX);
   assign pe_ey = (pe_d[D_W+H +: H] == PY);

   // N travels on the Y ring only, so its X field is never consulted
   assign w_re  = w_v & ~w_ex;
   assign w_rs  = w_v & w_ex & ~w_ey;
   assign w_rx  = w_v & w_ex & w_ey;
   assign n_rs  = n_v & ~n_ey;
   assign n_rx  = n_v & n_ey;
   assign pe_re = pe_v & ~pe_ex;
   assign pe_rs = pe_v & pe_ex & ~pe_ey;
   assign pe_rx = pe_v & pe_ex & pe_ey;

   assign rdy_e = ~e_v | ~e_b;
   assign rdy_s = ~s_v | ~s_b;
   assign rdy_x = ~x_v | ~x_b;

   always_comb begin
      g_e_w = 1'b0; g_e_pe = 1'b0;
      g_s_n = 1'b0; g_s_w = 1'b0; g_s_pe = 1'b0;
      g_x_n = 1'b0; g_x_w = 1'b0; g_x_pe = 1'b0;
      if (!rst) begin
         if (rdy_e) begin
            if (pe_pri && pe_re)  g_e_pe = 1'b1;
            else if (w_re)        g_e_w  = 1'b1;
            else if (pe_re)       g_e_pe = 1'b1;
         end
         if (rdy_s) begin
            if (pe_pri && pe_rs)  g_s_pe = 1'b1;
            else if (n_rs && w_rs) begin
               if (rr_s) g_s_w = 1'b1;
               else      g_s_n = 1'b1;
            end
            else if (n_rs)        g_s_n  = 1'b1;
            else if (w_rs)        g_s_w  = 1'b1;
            else if (pe_rs)       g_s_pe = 1'b1;
         end
         if (rdy_x) begin
            if (pe_pri && pe_rx)  g_x_pe = 1'b1;
            else if (n_rx && w_rx) begin
               if (rr_x) g_x_w = 1'b1;
               else      g_x_n = 1'b1;
            end
            else if (n_rx)        g_x_n  = 1'b1;
            else if (w_rx)        g_x_w  = 1'b1;
            else if (pe_rx)       g_x_pe = 1'b1;
         end
      end
   end

   // pointer moves only on a real N-vs-W contest won by one of them
   assign flip_s = n_rs & w_rs & (g_s_n | g_s_w);
   assign flip_x = n_rx & w_rx & (g_x_n | g_x_w);

   assign w_g  = g_e_w | g_s_w | g_x_w;
   assign n_g  = g_s_n | g_x_n;
   assign pe_g = g_e_pe | g_s_pe | g_x_pe;

   assign w_b  = rst | (w_v & ~w_g);
   assign n_b  = rst | (n_v & ~n_g);
   assign pe_b = rst | (pe_v & ~pe_g);

`ifdef DOR_STARVE_EN
   localparam int CW = $clog2(STARVE_LIM + 1);
   logic [CW-1:0] st_cnt;

   assign pe_pri = (st_cnt == CW'(STARVE_LIM));

   always_ff @(posedge clk) begin
      if (rst)                  st_cnt <= '0;
      else if (!pe_v || pe_g)   st_cnt <= '0;
      else if (pe_b && !pe_pri) st_cnt <= st_cnt + CW'(1);
   end
`else
   assign pe_pri = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         e_v  <= 1'b0; e_d <= '0;
         s_v  <= 1'b0; s_d <= '0;
         x_v  <= 1'b0; x_d <= '0;
         rr_s <= 1'b0;
         rr_x <= 1'b0;
      end else begin
         if (rdy_e) begin
            e_v <= g_e_w | g_e_pe;
            if (g_e_w)       e_d <= w_d;
            else if (g_e_pe) e_d <= pe_d;
         end
         if (rdy_s) begin
            s_v <= g_s_n | g_s_w | g_s_pe;
            if (g_s_n)       s_d <= n_d;
            else if (g_s_w)  s_d <= w_d;
            else if (g_s_pe) s_d <= pe_d;
         end
         if (rdy_x) begin
            x_v <= g_x_n | g_x_w | g_x_pe;
            if (g_x_n)       x_d <= n_d;
            else if (g_x_w)  x_d <= w_d;
            else if (g_x_pe) x_d <= pe_d;
         end
         if (flip_s) rr_s <= ~rr_s;
         if (flip_x) rr_x <= ~rr_x;
      end
   end
endmodule

// File: tb/tb_dor_route_switch.sv
// Directed bench for dor_route_switch at posx=posy=1, A_W=4, D_W=8, STARVE_LIM=3.
module tb_dor_route_switch;
   localparam int D_W = 8;
   localparam int A_W = 4;
   localparam int W   = A_W + D_W + 1;
`ifdef DOR_STARVE_EN
   localparam bit STV = 1'b1;
`else
   localparam bit STV = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         w_v, n_v, pe_v, e_b, s_b, x_b;
   logic [W-1:0] w_d, n_d, pe_d;
   logic         w_b, n_b, pe_b, e_v, s_v, x_v;
   logic [W-1:0] e_d, s_d, x_d;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dor_route_switch #(
      .D_W(D_W), .A_W(A_W), .posx(1), .posy(1), .STARVE_LIM(3)
   ) dut (
      .clk(clk), .rst(rst),
      .w_v(w_v), .w_d(w_d), .w_b(w_b),
      .n_v(n_v), .n_d(n_d), .n_b(n_b),
      .pe_v(pe_v), .pe_d(pe_d), .pe_b(pe_b),
      .e_v(e_v), .e_d(e_d), .e_b(e_b),
      .s_v(s_v), .s_d(s_d), .s_b(s_b),
      .x_v(x_v), .x_d(x_d), .x_b(x_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input logic t, input logic [1:0] y, input logic [1:0] x,
                                       input logic [7:0] d);
      return {t, y, x, d};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] pa, pb, pn, pw, pp;
      rst = 1'b1;
      w_v = 1'b0; n_v = 1'b0; pe_v = 1'b0;
      w_d = '0; n_d = '0; pe_d = '0;
      e_b = 1'b0; s_b = 1'b0; x_b = 1'b0;

      // reset state
      @(negedge clk); #1;
      chk("rst_w_b", w_b, 1); chk("rst_n_b", n_b, 1); chk("rst_pe_b", pe_b, 1);
      @(negedge clk);
      chk("rst_e_v", e_v, 0); chk("rst_s_v", s_v, 0); chk("rst_x_v", x_v, 0);
      chk("rst_e_d", e_d, 0);
      rst = 1'b0;

      // 1: W to (2,1) goes East in one cycle, top bit preserved
      pa = pk(1'b1, 2'd1, 2'd2, 8'hAB);
      w_v = 1'b1; w_d = pa; #1;
      chk("t1_w_b", w_b, 0);
      @(negedge clk);
      w_v = 1'b0;
      chk("t1_e_v", e_v, 1); chk("t1_e_d", e_d, pa);
      chk("t1_s_v", s_v, 0); chk("t1_x_v", x_v, 0);

      // 2: N and W both to S alternate N,W,N,W
      pn = pk(1'b0, 2'd3, 2'd1, 8'h11);
      pw = pk(1'b0, 2'd2, 2'd1, 8'h22);
      n_v = 1'b1; n_d = pn; w_v = 1'b1; w_d = pw;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t2_n_b%0d", i), n_b, (i % 2));
         chk($sformatf("t2_w_b%0d", i), w_b, 1 - (i % 2));
         @(negedge clk);
         chk($sformatf("t2_s_v%0d", i), s_v, 1);
         chk($sformatf("t2_s_d%0d", i), s_d, (i % 2) ? pw : pn);
      end
      n_v = 1'b0; w_v = 1'b0;

      // 3: E stalled by e_b for 3 cycles
      pa = pk(1'b0, 2'd1, 2'd0, 8'hA1);
      pb = pk(1'b1, 2'd1, 2'd0, 8'hB2);
      w_v = 1'b1; w_d = pa; #1;
      chk("t3_w_b_a", w_b, 0);
      @(negedge clk);
      chk("t3_e_d_a", e_d, pa);
      w_d = pb; e_b = 1'b1; #1;
      chk("t3_w_b0", w_b, 1);
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t3_e_d%0d", k), e_d, pa);
         #1;
         chk($sformatf("t3_w_b%0d", k), w_b, 1);
      end
      @(negedge clk);
      chk("t3_e_hold", e_d, pa); chk("t3_e_v_hold", e_v, 1);
      e_b = 1'b0; #1;
      chk("t3_w_b_rel", w_b, 0);
      @(negedge clk);
      w_v = 1'b0;
      chk("t3_e_d_b", e_d, pb);

      // 4: N and PE both exit; N first, PE next cycle
      pn = pk(1'b0, 2'd1, 2'd1, 8'h44);
      pp = pk(1'b1, 2'd1, 2'd1, 8'h55);
      n_v = 1'b1; n_d = pn; pe_v = 1'b1; pe_d = pp; #1;
      chk("t4_n_b", n_b, 0); chk("t4_pe_b", pe_b, 1);
      @(negedge clk);
      n_v = 1'b0;
      chk("t4_x_v", x_v, 1); chk("t4_x_d_n", x_d, pn);
      #1;
      chk("t4_pe_b2", pe_b, 0);
      @(negedge clk);
      pe_v = 1'b0;
      chk("t4_x_d_pe", x_d, pp);

      // 5: W and PE streaming to E
      pw = pk(1'b0, 2'd0, 2'd2, 8'h66);
      pp = pk(1'b0, 2'd0, 2'd3, 8'h77);
      w_v = 1'b1; w_d = pw; pe_v = 1'b1; pe_d = pp;
      for (int c = 1; c <= 6; c++) begin
         #1;
         chk($sformatf("t5_pe_b%0d", c), pe_b, (STV && c == 4) ? 0 : 1);
         chk($sformatf("t5_w_b%0d", c), w_b, (STV && c == 4) ? 1 : 0);
         @(negedge clk);
         chk($sformatf("t5_e_d%0d", c), e_d, (STV && c == 4) ? pp : pw);
      end
      w_v = 1'b0; pe_v = 1'b0;

      // 6: reset mid-stream with E and S full; rr_s left at 1 before reset
      pn = pk(1'b0, 2'd3, 2'd1, 8'h41);
      pw = pk(1'b0, 2'd2, 2'd1, 8'h31);
      pp = pk(1'b1, 2'd1, 2'd2, 8'h51);
      n_v = 1'b1; n_d = pn; w_v = 1'b1; w_d = pw; pe_v = 1'b1; pe_d = pp; #1;
      chk("t6_n_b_pre", n_b, 0); chk("t6_w_b_pre", w_b, 1);
      @(negedge clk);
      chk("t6_e_v_pre", e_v, 1); chk("t6_s_v_pre", s_v, 1);
      rst = 1'b1; #1;
      chk("t6_w_b_rst", w_b, 1); chk("t6_n_b_rst", n_b, 1); chk("t6_pe_b_rst", pe_b, 1);
      @(negedge clk);
      chk("t6_e_v", e_v, 0); chk("t6_s_v", s_v, 0); chk("t6_x_v", x_v, 0);
      chk("t6_e_d", e_d, 0); chk("t6_s_d", s_d, 0); chk("t6_x_d", x_d, 0);
      rst = 1'b0; #1;
      chk("t6_n_b_post", n_b, 0); chk("t6_w_b_post", w_b, 1); chk("t6_pe_b_post", pe_b, 0);
      @(negedge clk);
      n_v = 1'b0; w_v = 1'b0; pe_v = 1'b0;
      chk("t6_s_d_post", s_d, pn); chk("t6_e_d_post", e_d, pp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
